// File: rtl/spi_pkg.sv
// spi_pkg: widths and default idle byte shared by the SPI master and slave
package spi_pkg;
  localparam int SPI_BITS = 8;
  localparam int CNT_W = 3;
  localparam logic [SPI_BITS-1:0] DEFAULT_TX = 8'hFF;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rise/fall pulses against a third registered copy
module spi_sync_edge (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  // shift the async input through the synchronizer and edge-history stages
  always_comb sh_d = {sh_q[1:0], d};
  // synchronizer register
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) sh_q <= '0;
    else sh_q <= sh_d;
  assign q = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 byte-wide SPI target with single-entry tx holding register; SPI_SLAVE_OVERRUN_EN adds sticky error flags
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [SPI_BITS-1:0] DEFAULT_TX = spi_pkg::DEFAULT_TX
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                spi_clk,
  input  logic                spi_cs_l,
  input  logic                spi_din,
  output logic                spi_dout,
  output logic                spi_dout_en,
  input  logic [SPI_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic                rx_overrun,
  output logic                tx_underrun,
  input  logic                err_clr,
  input  logic                rx_ack
`endif
);
  logic clk_s, clk_rise, clk_fall, cs_s, cs_rise, cs_fall, din_s;
  logic act_rise, act_fall, cs_edge, byte_done, load, accept;
  logic busy_q, busy_d, pend_q, pend_d, full_q, full_d, rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [SPI_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, hold_q, hold_d;

  spi_sync_edge u_clk (.clk(clk), .reset_l(reset_l), .d(spi_clk), .q(clk_s), .rise(clk_rise), .fall(clk_fall));
  spi_sync_edge u_cs (.clk(clk), .reset_l(reset_l), .d(spi_cs_l), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge u_din (.clk(clk), .reset_l(reset_l), .d(spi_din), .q(din_s), .rise(), .fall());

  // next-state for select tracking, rx shifting, tx loading/shifting and the holding register
  always_comb begin
    act_rise = busy_q & ~cs_rise & clk_rise & clk_s;
    act_fall = busy_q & ~cs_rise & clk_fall & ~cs_s;
    cs_edge = cs_fall | cs_rise;
    byte_done = act_rise & (rx_cnt_q == CNT_W'(SPI_BITS - 1));
    load = cs_fall | (act_fall & pend_q);
    accept = tx_valid & ~full_q;
    busy_d = cs_fall | (busy_q & ~cs_rise);
    rx_sh_d = act_rise ? {rx_sh_q[SPI_BITS-2:0], din_s} : rx_sh_q;
    rx_cnt_d = cs_edge ? '0 : act_rise ? rx_cnt_q + 1'b1 : rx_cnt_q;
    rx_data_d = byte_done ? rx_sh_d : rx_data_q;
    rx_valid_d = byte_done;
    pend_d = cs_edge ? 1'b0 : byte_done ? 1'b1 : load ? 1'b0 : pend_q;
    tx_sh_d = load ? (full_q ? hold_q : DEFAULT_TX) : act_fall ? {tx_sh_q[SPI_BITS-2:0], 1'b0} : tx_sh_q;
    hold_d = accept ? tx_data : hold_q;
    full_d = accept | (full_q & ~load);
  end

  // state registers
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      busy_q <= 1'b0;
      pend_q <= 1'b0;
      full_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_cnt_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      tx_sh_q <= '0;
      hold_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      full_q <= full_d;
      rx_valid_q <= rx_valid_d;
      rx_cnt_q <= rx_cnt_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      tx_sh_q <= tx_sh_d;
      hold_q <= hold_d;
    end

  assign busy = busy_q;
  assign spi_dout_en = busy_q;
  assign spi_dout = busy_q & tx_sh_q[SPI_BITS-1];
  assign tx_ready = ~full_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic unread_q, unread_d, ovr_q, ovr_d, und_q, und_d;
  // a byte is unread from its strobe until acked; a new strobe over an unread byte is an overrun
  always_comb begin
    unread_d = rx_valid_q | (unread_q & ~rx_ack);
    ovr_d = (rx_valid_q & unread_q & ~rx_ack) | (ovr_q & ~err_clr);
    und_d = (load & ~full_q) | (und_q & ~err_clr);
  end
  // sticky error flags
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      unread_q <= 1'b0;
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      unread_q <= unread_d;
      ovr_q <= ovr_d;
      und_q <= und_d;
    end
  assign rx_overrun = ovr_q;
  assign tx_underrun = und_q;
`endif
endmodule
